// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential Booth multiplier with a start/busy/done handshake.
// Operands are sign- or zero-extended to WIDTH+2 bits, so one signed Booth
// datapath serves both signed and unsigned requests.
// Build option: define BOOTH_RADIX4_EN for radix-4 modified Booth
// ((WIDTH+2)/2 steps). Leave it undefined for radix-2 Booth (WIDTH+2 steps).
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     M_input,
  input  logic [WIDTH-1:0]     Q_input,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Z
);

  localparam int EW = WIDTH + 2;   // extended operand width
  localparam int AW = EW + 2;      // accumulator width, headroom for +-2M
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = EW / 2;
`else
  localparam int ITER = EW;
`endif
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic               load, step, last;
  logic [AW-1:0]      a_reg, a_step;
  logic [AW-1:0]      m_ext, m2_ext, addend, sum;
  logic [EW-1:0]      q_reg, m_reg, q_step, m_load, q_load;
  logic               qm1_reg, qm1_step;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] z_reg, z_next;

  assign last = (cnt_reg == CW'(1));

  // Operand extension applied at accept time.
  assign m_load = is_signed ? {{2{M_input[WIDTH-1]}}, M_input} : {2'b00, M_input};
  assign q_load = is_signed ? {{2{Q_input[WIDTH-1]}}, Q_input} : {2'b00, Q_input};

  assign m_ext  = {{2{m_reg[EW-1]}}, m_reg};
  assign m2_ext = {m_ext[AW-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and handshake outputs; start is only honoured when not iterating.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef BOOTH_RADIX4_EN
  // Radix-4 recoding of {Q[1],Q[0],Q-1}, add, then arithmetic shift by 2.
  always_comb begin
    addend = '0;
    case ({q_reg[1:0], qm1_reg})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m2_ext;
      3'b100:         addend = -m2_ext;
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum      = a_reg + addend;
    a_step   = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_step   = {sum[1:0], q_reg[EW-1:2]};
    qm1_step = q_reg[1];
  end
`else
  // Radix-2 recoding of {Q[0],Q-1}, add, then arithmetic shift by 1.
  always_comb begin
    addend = '0;
    case ({q_reg[0], qm1_reg})
      2'b01:   addend = m_ext;
      2'b10:   addend = -m_ext;
      default: addend = '0;
    endcase
    sum      = a_reg + addend;
    a_step   = {sum[AW-1], sum[AW-1:1]};
    q_step   = {sum[0], q_reg[EW-1:1]};
    qm1_step = q_reg[0];
  end
`endif

  // Low 2*WIDTH bits of {A,Q} after the final step form the exact product.
  assign z_next = {a_step[WIDTH-3:0], q_step};

  // Datapath registers: load on accept, iterate in RUN, capture Z on the last step.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_reg   <= '0;
      q_reg   <= '0;
      qm1_reg <= 1'b0;
      m_reg   <= '0;
      cnt_reg <= '0;
      z_reg   <= '0;
    end else if (load) begin
      a_reg   <= '0;
      q_reg   <= q_load;
      qm1_reg <= 1'b0;
      m_reg   <= m_load;
      cnt_reg <= CW'(ITER);
    end else if (step) begin
      a_reg   <= a_step;
      q_reg   <= q_step;
      qm1_reg <= qm1_step;
      cnt_reg <= cnt_reg - CW'(1);
      if (last) z_reg <= z_next;
    end
  end

  assign Z = z_reg;

endmodule
